// File: rtl/std_reg_arbiter.sv
// Round-robin write controller for one shared storage register.
// Each write runs grant/capture -> commit -> acknowledge; the stored value is always readable.
module std_reg_arbiter #(
    parameter int width = 32,
    parameter int num_req = 4,
    parameter logic [width-1:0] reset_val = '0,
    localparam int iw = (num_req > 1) ? $clog2(num_req) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [num_req-1:0]       req_valid,
    input  logic [num_req*width-1:0] req_data,
    output logic [num_req-1:0]       req_grant,
    output logic [num_req-1:0]       req_done,
    output logic [width-1:0]         out,
    output logic                     busy,
    output logic [1:0]               dbg_state,
    output logic [iw-1:0]            dbg_ptr
);

    // Handshake: a write is accepted when req_valid[i] and req_grant[i] are high in the
    // same cycle; the requester holds valid/data until then and may drop them afterwards.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t           state;
    logic [iw-1:0]    ptr;
    logic [iw-1:0]    cap_idx;
    logic [width-1:0] cap_data;
    logic [width-1:0] stored;
    logic             found;
    logic [iw-1:0]    sel_idx;

    // Search ptr, ptr+1, ... wrapping at num_req; the first pending requester wins.
    always_comb begin
        int j;
        j       = 0;
        found   = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < num_req; k++) begin
            j = int'(ptr) + k;
            if (j >= num_req) j = j - num_req;
            if (!found && req_valid[j]) begin
                found   = 1'b1;
                sel_idx = iw'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            stored   <= reset_val;
            ptr      <= '0;
            cap_data <= '0;
            cap_idx  <= '0;
            req_done <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cap_data <= req_data[sel_idx*width +: width];
                        cap_idx  <= sel_idx;
                        busy     <= 1'b1;
                        state    <= COMMIT;
                    end
                end
                COMMIT: begin
                    stored   <= cap_data;
                    req_done <= num_req'(1) << cap_idx;
                    state    <= ACK;
                end
                ACK: begin
                    req_done <= '0;
                    busy     <= 1'b0;
                    ptr      <= (cap_idx == iw'(num_req - 1)) ? '0 : cap_idx + 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_grant = (state == IDLE && found) ? (num_req'(1) << sel_idx) : '0;
    assign out       = stored;
    assign dbg_state = state;
    assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_std_reg_arbiter.sv
// Directed bench for std_reg_arbiter: expected grants/writes are queued by the stimulus
// and a negedge monitor pops and compares them whenever the DUT presents grant or done.
module tb_std_reg_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam logic [W-1:0] RV = 8'h5A;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_grant;
    logic [N-1:0]   req_done;
    logic [W-1:0]   out;
    logic           busy;
    logic [1:0]     dbg_state;
    logic [1:0]     dbg_ptr;

    std_reg_arbiter #(.width(W), .num_req(N), .reset_val(RV)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_grant(req_grant), .req_done(req_done), .out(out), .busy(busy),
        .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_grant_cyc = -100;
    logic mon_en = 1'b0;

    logic [1:0]   grant_q[$];
    logic [W+1:0] exp_q[$];   // {idx, data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [N-1:0] mask, input logic [W-1:0] d0,
                           input logic [W-1:0] d1, input logic [W-1:0] d2, input logic [W-1:0] d3);
        req_valid = mask;
        req_data  = {d3, d2, d1, d0};
    endtask

    task automatic expect_write(input logic [1:0] idx, input logic [W-1:0] d);
        grant_q.push_back(idx);
        exp_q.push_back({idx, d});
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (req_grant != '0) begin
                check("grant_onehot", {31'b0, $onehot(req_grant)}, 32'd1);
                check("grant_not_busy", {31'b0, busy}, 32'd0);
                if (grant_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got 0x%0h expected none (cycle %0d)", req_grant, cyc);
                end else begin
                    logic [1:0] gi;
                    gi = grant_q.pop_front();
                    check("grant", {28'b0, req_grant}, 32'd1 << gi);
                end
                last_grant_cyc = cyc;
            end
            if (req_done != '0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got 0x%0h expected none (cycle %0d)", req_done, cyc);
                end else begin
                    logic [W+1:0] e;
                    e = exp_q.pop_front();
                    check("done", {28'b0, req_done}, 32'd1 << e[W+1:W]);
                    check("done_out", {24'b0, out}, {24'b0, e[W-1:0]});
                    check("done_latency", cyc, last_grant_cyc + 2);
                    check("done_busy", {31'b0, busy}, 32'd1);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        set_req('0, 0, 0, 0, 0);

        // 1: reset state, then idle with no requests
        step();
        step();
        @(negedge clk);
        check("rst_out", {24'b0, out}, {24'b0, RV});
        check("rst_grant", {28'b0, req_grant}, 32'd0);
        check("rst_done", {28'b0, req_done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            check("idle_out", {24'b0, out}, {24'b0, RV});
            check("idle_busy", {31'b0, busy}, 32'd0);
        end

        // 2: single write from requester 2
        step();
        expect_write(2'd2, 8'h33);
        set_req(4'b0100, 0, 0, 8'h33, 0);
        step();
        set_req('0, 0, 0, 0, 0);
        @(negedge clk);
        check("commit_busy", {31'b0, busy}, 32'd1);
        check("commit_out_old", {24'b0, out}, {24'b0, RV});
        step();
        step();
        @(negedge clk);
        check("after_state", {30'b0, dbg_state}, 32'd0);
        check("after_ptr", {30'b0, dbg_ptr}, 32'd3);
        check("after_out", {24'b0, out}, 32'h33);
        check("after_busy", {31'b0, busy}, 32'd0);

        // 3: round robin from ptr=0, all continuously valid
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        expect_write(2'd0, 8'h10);
        expect_write(2'd1, 8'h11);
        expect_write(2'd2, 8'h12);
        expect_write(2'd3, 8'h13);
        expect_write(2'd0, 8'h10);
        set_req(4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
        for (int i = 0; i < 13; i++) step();
        set_req('0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        check("rr_ptr", {30'b0, dbg_ptr}, 32'd1);

        // 4: serve 3, then 0 wins over 3 after wrap, then 3 is served
        expect_write(2'd3, 8'h43);
        set_req(4'b1000, 0, 0, 0, 8'h43);
        step();
        set_req('0, 0, 0, 0, 0);
        step();
        step();
        expect_write(2'd0, 8'h50);
        expect_write(2'd3, 8'h53);
        set_req(4'b1001, 8'h50, 0, 0, 8'h53);
        step();
        set_req(4'b1000, 0, 0, 0, 8'h53);
        step();
        step();
        step();
        set_req('0, 0, 0, 0, 0);
        step();
        step();

        // 5: requester 1 queued during busy; requester 2 withdraws before IDLE
        expect_write(2'd0, 8'h60);
        expect_write(2'd1, 8'h61);
        set_req(4'b0001, 8'h60, 0, 0, 0);
        step();
        set_req(4'b0110, 0, 8'h61, 8'h62, 0);
        step();
        set_req(4'b0010, 0, 8'h61, 0, 0);
        step();
        step();
        set_req('0, 0, 0, 0, 0);
        step();
        step();
        @(negedge clk);
        check("wd_out", {24'b0, out}, 32'h61);
        check("wd_ptr", {30'b0, dbg_ptr}, 32'd2);

        // 6: reset during COMMIT discards the write
        grant_q.push_back(2'd2);
        set_req(4'b0100, 0, 0, 8'hFF, 0);
        step();
        set_req('0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out", {24'b0, out}, {24'b0, RV});
        check("mid_rst_state", {30'b0, dbg_state}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_ptr", {30'b0, dbg_ptr}, 32'd0);
        step();
        step();
        @(negedge clk);
        check("mid_rst_hold", {24'b0, out}, {24'b0, RV});
        expect_write(2'd1, 8'h71);
        set_req(4'b1010, 0, 8'h71, 0, 8'h73);
        step();
        set_req('0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        check("final_out", {24'b0, out}, 32'h71);
        check("grant_q_empty", grant_q.size(), 32'd0);
        check("exp_q_empty", exp_q.size(), 32'd0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
